// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding, frame constants
// and the default bit period.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DATA_BITS            = 8;
    localparam int BIT_CNT_W            = $clog2(DATA_BITS);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } tx_state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and a one-cycle overflow pulse
// for writes that arrive with no free slot.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             push;
    logic             pop;

    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    always_comb begin
        pop        = rd && (count != '0);
        push       = wr && ((count != COUNT_FULL) || pop);
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count    <= count_next;
            full     <= (count_next == COUNT_FULL);
            empty    <= (count_next == '0);
            overflow <= wr && !push;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered 8N1 UART transmitter; define UART_TX_PARITY_EN to insert an even
// parity bit between data bit 7 and the stop bit.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] txData,
    input  logic       txDataWr,
    output logic       tx,
    output logic       txBusy,
    output logic       fifoFull,
    output logic       fifoEmpty,
    output logic       overflow,
    output logic [2:0] fsm_state
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);

    tx_state_t              state;
    logic [BAUD_W-1:0]      baud;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS-1:0]   fifo_data;
    logic                   pop;
    logic                   baud_done;
`ifdef UART_TX_PARITY_EN
    logic                   parity_bit;
`endif

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr       (txDataWr),
        .wr_data  (txData),
        .rd       (pop),
        .rd_data  (fifo_data),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .overflow (overflow)
    );

    assign pop       = (state == IDLE) && !fifoEmpty;
    assign baud_done = (baud == BAUD_LAST);
    assign txBusy    = (state != IDLE) || !fifoEmpty;
    assign fsm_state = state;

    // tx is loaded on each transition, so the line changes on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    baud <= '0;
                    if (!fifoEmpty) begin
                        shreg   <= fifo_data;
                        bit_cnt <= '0;
                        tx      <= 1'b0;
                        state   <= START;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= even_parity(fifo_data);
`endif
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud  <= '0;
                        tx    <= shreg[0];
                        state <= DATA;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            tx      <= shreg[1];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_done) begin
                        baud  <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_done) begin
                        baud  <= '0;
                        tx    <= 1'b1;
                        state <= IDLE;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    baud  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: serial frames are decoded and scored against an
// expected byte queue; UART_TX_PARITY_EN selects the 11-bit frame checks.
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS   = 11;
    localparam int TOTAL_FRAMES = 63;
`else
    localparam int FRAME_BITS   = 10;
    localparam int TOTAL_FRAMES = 61;
`endif
    localparam int STOP_SAMPLE = (FRAME_BITS - 1) * CPB + CPB / 2;

    logic       clk;
    logic       rst;
    logic [7:0] txData;
    logic       txDataWr;
    logic       tx;
    logic       txBusy;
    logic       fifoFull;
    logic       fifoEmpty;
    logic       overflow;
    logic [2:0] fsm_state;

    int         n_checks;
    int         n_fail;
    int         cyc;
    int         ovf_count;
    int         frames_rx;
    int         rx_cnt;
    logic       rx_active;
    logic [7:0] rx_byte;
    logic       rx_par;
    logic       last_parity;
    logic [7:0] exp_q[$];
    int         start_cyc[$];

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .txData    (txData),
        .txDataWr  (txDataWr),
        .tx        (tx),
        .txBusy    (txBusy),
        .fifoFull  (fifoFull),
        .fifoEmpty (fifoEmpty),
        .overflow  (overflow),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (!rst && overflow === 1'b1) ovf_count++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // serial receiver / scoreboard, samples each bit mid-period on the falling clock
    always @(negedge clk) begin
        if (rst) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
                start_cyc.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == CPB / 2) check("rx_start_bit", {31'b0, tx}, 0);
            if (rx_cnt >= CPB + CPB / 2 && rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2)
                rx_byte[(rx_cnt / CPB) - 1] = tx;
            if (rx_cnt == 9 * CPB + CPB / 2) rx_par = tx;
            if (rx_cnt == STOP_SAMPLE) begin
                check("rx_stop_bit", {31'b0, tx}, 1);
                check("rx_expected_pending", {31'b0, exp_q.size() != 0}, 1);
                if (exp_q.size() != 0) begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("rx_byte", {24'b0, rx_byte}, {24'b0, e});
`ifdef UART_TX_PARITY_EN
                    check("rx_parity", {31'b0, rx_par}, {31'b0, ^e});
`endif
                end
                last_parity = rx_par;
                frames_rx++;
                rx_active = 1'b0;
            end
        end
    end

    // driver tasks
    task automatic send(input logic [7:0] b, input bit accept);
        @(negedge clk);
        txData   = b;
        txDataWr = 1'b1;
        if (accept) exp_q.push_back(b);
    endtask

    task automatic release_wr();
        @(negedge clk);
        txDataWr = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (txBusy === 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'b0, txBusy}, 0);
    endtask

    task automatic wait_empty(input int limit);
        int n;
        n = 0;
        while (fifoEmpty !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("empty_timeout", {31'b0, fifoEmpty}, 1);
    endtask

    initial begin
        int n;
        int sz;
        int ovf_base;
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        ovf_count = 0;
        frames_rx = 0;
        rx_active = 1'b0;
        rx_cnt    = 0;
        rx_byte   = '0;
        rx_par    = 1'b0;
        last_parity = 1'b0;
        txData    = '0;
        txDataWr  = 1'b0;
        rst       = 1'b1;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_tx", {31'b0, tx}, 1);
        check("rst_busy", {31'b0, txBusy}, 0);
        check("rst_full", {31'b0, fifoFull}, 0);
        check("rst_empty", {31'b0, fifoEmpty}, 1);
        check("rst_overflow", {31'b0, overflow}, 0);
        check("rst_state", {29'b0, fsm_state}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // single byte '*': tx falls one edge after the write edge
        send(8'h2A, 1);
        release_wr();
        check("t1_not_empty", {31'b0, fifoEmpty}, 0);
        check("t1_busy", {31'b0, txBusy}, 1);
        check("t1_tx_still_idle", {31'b0, tx}, 1);
        @(negedge clk);
        check("t1_tx_fall", {31'b0, tx}, 0);
        check("t1_popped", {31'b0, fifoEmpty}, 1);
        check("t1_state_start", {29'b0, fsm_state}, 1);
        wait_idle(200, n);
        check("t1_busy_len", n, FRAME_BITS * CPB);
        check("t1_tx_idle_after", {31'b0, tx}, 1);
        repeat (3) @(negedge clk);

        // 'A' then '*' back to back: one idle clock between frames
        ovf_base = ovf_count;
        send(8'h41, 1);
        send(8'h2A, 1);
        release_wr();
        wait_idle(400, n);
        sz = start_cyc.size();
        check("t2_gap", start_cyc[sz-1] - start_cyc[sz-2], FRAME_BITS * CPB + 1);
        check("t2_no_overflow", ovf_count - ovf_base, 0);
        repeat (3) @(negedge clk);

        // 18 consecutive writes from idle: 17 fit (first pop frees a slot), the 18th drops
        ovf_base = ovf_count;
        for (int i = 0; i < 18; i++) send(8'(8'h80 + i), i < 17);
        release_wr();
        check("t3_overflow_pulse", {31'b0, overflow}, 1);
        check("t3_full", {31'b0, fifoFull}, 1);
        @(negedge clk);
        check("t3_overflow_clear", {31'b0, overflow}, 0);
        check("t3_still_full", {31'b0, fifoFull}, 1);
        wait_idle(18 * FRAME_BITS * CPB + 100, n);
        check("t3_overflow_count", ovf_count - ovf_base, 1);
        repeat (3) @(negedge clk);

        // 40 bytes in bursts of 10: pointers wrap more than twice
        ovf_base = ovf_count;
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 10; j++) send(8'((b * 10 + j) * 7 + 3), 1);
            release_wr();
            wait_empty(12 * FRAME_BITS * CPB);
        end
        wait_idle(3 * FRAME_BITS * CPB, n);
        check("t4_no_overflow", ovf_count - ovf_base, 0);
        check("t4_queue_drained", exp_q.size(), 0);
        repeat (3) @(negedge clk);

        // reset during data bit 3 of 0xA5 with 0x3C queued behind it
        send(8'hA5, 1);
        send(8'h3C, 1);
        release_wr();
        repeat (17) @(negedge clk);
        check("t5_in_data", {29'b0, fsm_state}, 2);
        check("t5_tx_low_bit3", {31'b0, tx}, 0);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t5_tx_async_high", {31'b0, tx}, 1);
        check("t5_fifo_flushed", {31'b0, fifoEmpty}, 1);
        check("t5_busy_low", {31'b0, txBusy}, 0);
        check("t5_state_idle", {29'b0, fsm_state}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send(8'h96, 1);
        release_wr();
        @(negedge clk);
        check("t5_clean_start", {31'b0, tx}, 0);
        wait_idle(200, n);
        check("t5_busy_len", n, FRAME_BITS * CPB);
        repeat (3) @(negedge clk);

`ifdef UART_TX_PARITY_EN
        // even parity: 0x07 has three ones, 0x03 has two
        send(8'h07, 1);
        release_wr();
        @(negedge clk);
        wait_idle(200, n);
        check("t6_frame_len", n, 11 * CPB);
        check("t6_parity_07", {31'b0, last_parity}, 1);
        repeat (3) @(negedge clk);
        send(8'h03, 1);
        release_wr();
        wait_idle(200, n);
        check("t6_parity_03", {31'b0, last_parity}, 0);
        repeat (3) @(negedge clk);
`endif

        check("frames_received", frames_rx, TOTAL_FRAMES);
        check("expected_left", exp_q.size(), 0);
        check("final_tx_idle", {31'b0, tx}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
